pio_edge_in: RTL and testbench
==============================

# pio_edge_in

Avalon-MM slave input port: samples a WIDTH-bit asynchronous input bus (push-buttons, switches, LCD busy flag) and lets the Nios II read it. It synchronizes the bus, detects edges per bit, latches them in a sticky edge-capture register, and raises a maskable level interrupt. It is the read-side counterpart to the team's single-register output PIOs and uses the same 2-bit address / 32-bit data slave port with zero wait states.

## Interface
- WIDTH, 4: number of input bits (1..32).
- SYNC_STAGES, 2: synchronizer flip-flops per bit (2..4).
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.
- DEBOUNCE_CYCLES, 16: stable-cycle count required by the debounce filter (only used with PIO_DEBOUNCE_EN).
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data, combinational from address, zero-extended.
- irq  out  1  level interrupt.

## Operation
- Register map:
  - addr 0 DATA (RO): filtered synchronized input.
  - addr 1: reads 0; writes ignored.
  - addr 2 IRQMASK (RW): WIDTH bits.
  - addr 3 EDGECAP (R/W1C).
- Write qualifier is chipselect && !write_n. Reads have no side effects; EDGECAP is never cleared by a read.
- Synchronizer: SYNC_STAGES-deep chain per bit. The last stage is the synchronized value `s`.
- Filtered value `f`:
  - Without debounce, `f` = `s`.
  - With debounce, see Configuration.
- Edge detect: `prev` registers `f` every cycle.
  - rise = f & ~prev; fall = ~f & prev.
  - Selected by EDGE_TYPE; EDGE_TYPE 2 uses rise | fall.
- Startup arm counter: edge detection is suppressed for SYNC_STAGES+1 cycles after reset deassertion, so an input that is high at reset does not capture a false rising edge.
- EDGECAP[i] sets on a detected edge and stays set until written 1.
  - Written 0 bits are unchanged.
  - If a detection and a W1C hit the same bit in the same cycle, set wins.
- irq = |(EDGECAP & IRQMASK). It is combinational from registers, so there is no extra delay.
- Reset clears to 0: sync chain, `f`, `prev`, debounce counters, EDGECAP, IRQMASK, and arm counter. Outputs are therefore readdata = 0 and irq = 0 during reset.
- Reset asserted mid-operation aborts everything immediately; pending edges are lost.

## Timing
- in_port change before edge k is visible in DATA after edge k+SYNC_STAGES-1, i.e. SYNC_STAGES cycles.
- The corresponding EDGECAP bit sets at the next edge (SYNC_STAGES+1 total). irq rises in the same cycle if the bit is masked in.
- A W1C write at edge k clears the bit and deasserts irq after edge k.
- An IRQMASK write takes effect on irq after the writing edge.
- Input pulses shorter than one clk period may be missed. No capture guarantee below 2 cycles of stable level.

## Configuration
- PIO_DEBOUNCE_EN defined:
  - Per-bit counter, width clog2(DEBOUNCE_CYCLES+1).
  - While `s` != `f`, the counter increments. When it reaches DEBOUNCE_CYCLES, `f` takes `s` and the counter clears.
  - Any cycle with `s` == `f` clears the counter.
  - Adds DEBOUNCE_CYCLES cycles of latency to DATA, EDGECAP and irq.
- Not defined: `f` = `s`, no counters are synthesized, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset and arm suppression:
  - Stimulus: hold in_port = 4'hF through reset release.
  - Required: DATA reads 0xF after SYNC_STAGES+1 cycles; EDGECAP stays 0; irq stays 0.
- Rising capture and interrupt:
  - Stimulus: EDGE_TYPE 0, IRQMASK = 0x2, toggle bit1 0→1.
  - Required: EDGECAP reads 0x2 exactly 3 cycles later (SYNC_STAGES 2); irq = 1.
  - Then write 0x2 to addr 3: EDGECAP = 0, irq = 0 the next cycle.
- Mask behaviour:
  - Stimulus: IRQMASK = 0, raise bit0.
  - Required: EDGECAP = 0x1 and irq = 0. Writing IRQMASK = 0x1 makes irq = 1 the next cycle.
- Set-beats-clear:
  - Stimulus: W1C of bit2 in the same cycle bit2 edge is detected.
  - Required: EDGECAP bit2 remains 1.
- Any-edge and W1C selectivity:
  - Stimulus: EDGE_TYPE 2, pulse bits 0 and 3 high for 5 cycles, then write 0x1 to addr 3.
  - Required: EDGECAP = 0x9 after the pulse; 0x8 after the write.
- Debounce (PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES 16):
  - Stimulus 1: bit0 glitches high for 10 cycles.
  - Required: DATA stays 0 and EDGECAP stays 0.
  - Stimulus 2: bit0 held high.
  - Required: DATA bit0 = 1 after 2+16 cycles; EDGECAP = 0x1 one cycle later.

Source files
------------

// File: rtl/pio_edge_in.sv
// Avalon-MM input PIO that synchronizes an async bus, captures edges in a sticky W1C register and raises a maskable irq.
// Optional debounce filter is enabled by defining PIO_DEBOUNCE_EN.
module pio_edge_in #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ArmMax = SYNC_STAGES + 1;
  localparam int ArmW   = $clog2(ArmMax + 1);

  generate
    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        EDGE_TYPE < 0 || EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("pio_edge_in: illegal parameter value");
    end
  endgenerate

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [ArmW-1:0]  arm_cnt;
  logic             armed;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0]  db_cnt [WIDTH];
  logic [WIDTH-1:0] f_q;

  // A bit only follows s once it has disagreed with f for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == f_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CntLast) begin
          f_q[i]    <= s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign f = f_q;
`else
  assign f = s;
`endif

  // The arm counter keeps a bus that is already high at reset from looking like a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      arm_cnt <= '0;
    end else begin
      prev_q <= f;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign armed = (arm_cnt == ArmW'(ArmMax));
  assign rise  = f & ~prev_q;
  assign fall  = ~f & prev_q;

  always_comb begin
    edge_det = '0;
    if (armed) begin
      case (EDGE_TYPE)
        0:       edge_det = rise;
        1:       edge_det = fall;
        default: edge_det = rise | fall;
      endcase
    end
  end

  assign wr_en    = chipselect & ~write_n;
  assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // New detections are OR-ed in after the W1C so a coincident edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~clr_mask) | edge_det;
    end
  end

  assign irq = |(edge_cap & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = f;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_edge_in.sv
// Bench for pio_edge_in: three instances (rising/falling/any edge) checked against a history-based reference model.
// With PIO_DEBOUNCE_EN defined only the directed debounce sequence runs.
module tb_pio_edge_in;

  localparam int SYNC = 2;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd [3];
  logic [2:0]  irqv;

  int total;
  int bad;

  logic [3:0]  hist [0:2047];
  int          cyc;
  logic [3:0]  m_ec [3];
  logic [3:0]  m_mask;

  logic [31:0] cap_data [3];
  logic [31:0] cap_mask [3];
  logic [31:0] cap_ec   [3];
  logic [31:0] cap_zero [3];
  logic        cap_irq  [3];

  pio_edge_in #(.WIDTH(4), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irqv[0]));

  pio_edge_in #(.WIDTH(4), .SYNC_STAGES(SYNC), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irqv[1]));

  pio_edge_in #(.WIDTH(4), .SYNC_STAGES(SYNC), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irqv[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // DATA after edge k is the input seen SYNC-1 edges earlier; zero until the chain has filled.
  function automatic logic [3:0] data_after(input int k);
    if (k < SYNC) return 4'h0;
    return hist[k-SYNC+1];
  endfunction

  task automatic model_edge(input logic [3:0] in_val, input logic wr, input logic [1:0] addr,
                            input logic [31:0] wd);
    logic [3:0] cur;
    logic [3:0] old;
    logic [3:0] clr;
    logic [3:0] det [3];
    cyc++;
    hist[cyc] = in_val;
    cur = data_after(cyc - 1);
    old = data_after(cyc - 2);
    det[0] = cur & ~old;
    det[1] = ~cur & old;
    det[2] = cur ^ old;
    if (cyc < SYNC + 2) begin
      for (int t = 0; t < 3; t++) det[t] = 4'h0;
    end
    clr = (wr && addr == 2'd3) ? wd[3:0] : 4'h0;
    for (int t = 0; t < 3; t++) m_ec[t] = (m_ec[t] & ~clr) | det[t];
    if (wr && addr == 2'd2) m_mask = wd[3:0];
  endtask

  task automatic applyStimulus(input logic [3:0] in_val, input logic wr, input logic [1:0] addr,
                               input logic [31:0] wd);
    in_port    = in_val;
    chipselect = wr;
    write_n    = ~wr;
    address    = addr;
    writedata  = wd;
    @(posedge clk);
    model_edge(in_val, wr, addr, wd);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic checkOutput(input string tag);
    address = 2'd0; #1;
    for (int t = 0; t < 3; t++) cap_data[t] = rd[t];
    address = 2'd2; #1;
    for (int t = 0; t < 3; t++) cap_mask[t] = rd[t];
    address = 2'd3; #1;
    for (int t = 0; t < 3; t++) begin
      cap_ec[t]  = rd[t];
      cap_irq[t] = irqv[t];
    end
    address = 2'd1; #1;
    for (int t = 0; t < 3; t++) cap_zero[t] = rd[t];
    for (int t = 0; t < 3; t++) begin
      cmp($sformatf("%s mask t%0d", tag, t), cap_mask[t], {28'h0, m_mask});
      cmp($sformatf("%s addr1 t%0d", tag, t), cap_zero[t], 32'h0);
`ifndef PIO_DEBOUNCE_EN
      cmp($sformatf("%s data t%0d", tag, t), cap_data[t], {28'h0, data_after(cyc)});
      cmp($sformatf("%s edgecap t%0d", tag, t), cap_ec[t], {28'h0, m_ec[t]});
      cmp($sformatf("%s irq t%0d", tag, t), {31'h0, cap_irq[t]}, {31'h0, |(m_ec[t] & m_mask)});
`endif
    end
  endtask

  // Reset is asserted between edges so the async clear can be observed before any clock.
  task automatic do_reset(input logic [3:0] in_val);
    @(negedge clk);
    reset_n    = 1'b0;
    in_port    = in_val;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd3;
    #1;
    for (int t = 0; t < 3; t++) begin
      cmp($sformatf("reset edgecap t%0d", t), rd[t], 32'h0);
      cmp($sformatf("reset irq t%0d", t), {31'h0, irqv[t]}, 32'h0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
    m_mask  = 4'h0;
    for (int t = 0; t < 3; t++) m_ec[t] = 4'h0;
  endtask

  initial begin
    logic [3:0] cur_in;
    int         r;
    total      = 0;
    bad        = 0;
    cyc        = 0;
    m_mask     = 4'h0;
    for (int t = 0; t < 3; t++) m_ec[t] = 4'h0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'h0;

`ifndef PIO_DEBOUNCE_EN
    $display("[TB] arm suppression with inputs high through reset");
    do_reset(4'hF);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'hF, 1'b0, 2'd0, 32'h0);
      checkOutput("arm");
    end
    cmp("arm data final", cap_data[0], 32'hF);
    cmp("arm edgecap final", cap_ec[2], 32'h0);
    cmp("arm irq final", {31'h0, cap_irq[0]}, 32'h0);

    $display("[TB] rising capture and W1C");
    do_reset(4'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h0, 1'b0, 2'd0, 32'h0);
      checkOutput("idle");
    end
    applyStimulus(4'h0, 1'b1, 2'd2, 32'h2); checkOutput("mask2");
    applyStimulus(4'h2, 1'b0, 2'd0, 32'h0); checkOutput("rise1");
    cmp("rise ec after 1", cap_ec[0], 32'h0);
    applyStimulus(4'h2, 1'b0, 2'd0, 32'h0); checkOutput("rise2");
    cmp("rise ec after 2", cap_ec[0], 32'h0);
    applyStimulus(4'h2, 1'b0, 2'd0, 32'h0); checkOutput("rise3");
    cmp("rise ec after 3", cap_ec[0], 32'h2);
    cmp("rise irq after 3", {31'h0, cap_irq[0]}, 32'h1);
    applyStimulus(4'h2, 1'b1, 2'd3, 32'h2); checkOutput("w1c");
    cmp("w1c ec", cap_ec[0], 32'h0);
    cmp("w1c irq", {31'h0, cap_irq[0]}, 32'h0);

    $display("[TB] mask behaviour");
    applyStimulus(4'h2, 1'b1, 2'd2, 32'h0); checkOutput("mask0");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'h3, 1'b0, 2'd0, 32'h0);
      checkOutput("bit0 rise");
    end
    cmp("masked ec", cap_ec[0], 32'h1);
    cmp("masked irq", {31'h0, cap_irq[0]}, 32'h0);
    applyStimulus(4'h3, 1'b1, 2'd2, 32'h1); checkOutput("mask1");
    cmp("unmasked irq", {31'h0, cap_irq[0]}, 32'h1);

    $display("[TB] set beats clear");
    applyStimulus(4'h3, 1'b1, 2'd3, 32'hF); checkOutput("clear all");
    cmp("cleared ec", cap_ec[0], 32'h0);
    applyStimulus(4'h7, 1'b0, 2'd0, 32'h0); checkOutput("bit2 a");
    applyStimulus(4'h7, 1'b0, 2'd0, 32'h0); checkOutput("bit2 b");
    applyStimulus(4'h7, 1'b1, 2'd3, 32'h4); checkOutput("bit2 w1c");
    cmp("set beats clear ec", cap_ec[0], 32'h4);

    $display("[TB] any-edge and W1C selectivity");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h0, 1'b0, 2'd0, 32'h0);
      checkOutput("drop");
    end
    applyStimulus(4'h0, 1'b1, 2'd3, 32'hF); checkOutput("clear any");
    cmp("any cleared", cap_ec[2], 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h9, 1'b0, 2'd0, 32'h0);
      checkOutput("pulse");
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h0, 1'b0, 2'd0, 32'h0);
      checkOutput("post pulse");
    end
    cmp("any ec after pulse", cap_ec[2], 32'h9);
    applyStimulus(4'h0, 1'b1, 2'd3, 32'h1); checkOutput("w1c bit0");
    cmp("any ec after w1c", cap_ec[2], 32'h8);

    $display("[TB] mid-operation reset then randomized traffic");
    do_reset(4'h0);
    cur_in = 4'h0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) cur_in = 4'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        0:       applyStimulus(cur_in, 1'b1, 2'd2, $urandom);
        1:       applyStimulus(cur_in, 1'b1, 2'd3, $urandom);
        2:       applyStimulus(cur_in, 1'b1, 2'($urandom_range(0, 1)), $urandom);
        default: applyStimulus(cur_in, 1'b0, 2'd0, 32'h0);
      endcase
      checkOutput("rand");
    end
`else
    $display("[TB] debounce glitch rejection and latency");
    do_reset(4'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h0, 1'b0, 2'd0, 32'h0);
      checkOutput("db idle");
    end
    for (int i = 0; i < 30; i++) begin
      applyStimulus((i < 10) ? 4'h1 : 4'h0, 1'b0, 2'd0, 32'h0);
      checkOutput("db glitch");
      cmp("glitch data", cap_data[0], 32'h0);
      cmp("glitch ec", cap_ec[0], 32'h0);
    end
    for (int j = 1; j <= 19; j++) begin
      applyStimulus(4'h1, 1'b0, 2'd0, 32'h0);
      checkOutput("db hold");
      cmp($sformatf("hold data %0d", j), cap_data[0], (j >= 18) ? 32'h1 : 32'h0);
      cmp($sformatf("hold ec %0d", j), cap_ec[0], (j >= 19) ? 32'h1 : 32'h0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
